// File: rtl/riscv_dmem_arbiter.sv
// Two-master arbiter for the single data-memory port.
// The processor (P) normally wins. A bounded-wait counter forces a slot
// for the debug/loader master (D), and out-of-window accesses are answered
// with an error instead of touching memory.
module riscv_dmem_arbiter #(
  parameter logic [31:0] DATA_START_ADDRESS = 32'h00800000,
  parameter int          DATA_BRAMS         = 2,
  parameter int          MAX_WAIT           = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p_req_i,
  input  logic        p_we_i,
  input  logic [31:0] p_addr_i,
  input  logic [31:0] p_wdata_i,
  output logic        p_gnt_o,
  output logic        p_rvalid_o,
  output logic [31:0] p_rdata_o,
  output logic        p_err_o,

  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,

  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  // Lowest address bit that selects the data window.
  localparam int         WinLsb  = 11 + DATA_BRAMS;
  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic {
    OwnerP = 1'b0,
    OwnerD = 1'b1
  } owner_e;

  logic       pGnt;
  logic       dGnt;
  logic       anyGnt;
  logic       forceD;
  logic       winWe;
  logic       winInWindow;
  logic       pInWindow;
  logic       dInWindow;

  logic [3:0] waitCnt_q, waitCnt_d;
  logic       respValid_q, respValid_d;
  owner_e     respOwner_q, respOwner_d;
  logic       respErr_q, respErr_d;
  logic       respIsRead_q, respIsRead_d;

  // Window decode for both requesters.
  assign pInWindow = (p_addr_i[31:WinLsb] == DATA_START_ADDRESS[31:WinLsb]);
  assign dInWindow = (d_addr_i[31:WinLsb] == DATA_START_ADDRESS[31:WinLsb]);

  // Grant selection: P has priority until D has waited MAX_WAIT cycles. Both grants are held low in reset.
  always_comb begin
    forceD = (waitCnt_q == MaxWait);
    pGnt   = rst_n & p_req_i & ~(d_req_i & forceD);
    dGnt   = rst_n & d_req_i & (~p_req_i | forceD);
    anyGnt = pGnt | dGnt;
  end

  assign p_gnt_o = pGnt;
  assign d_gnt_o = dGnt;

  // Memory mux: follow D only while D holds the grant, otherwise follow P.
  always_comb begin
    mem_addr_o  = p_addr_i;
    mem_wdata_o = p_wdata_i;
    winWe       = p_we_i;
    winInWindow = pInWindow;
    if (dGnt) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      winWe       = d_we_i;
      winInWindow = dInWindow;
    end
    mem_we_o = winWe & winInWindow & anyGnt;
  end

  // Next state for the wait counter and the response stage.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (dGnt) begin
      waitCnt_d = 4'd0;
    end else if (d_req_i && (waitCnt_q != MaxWait)) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end

    respValid_d  = anyGnt;
    respOwner_d  = dGnt ? OwnerD : OwnerP;
    respErr_d    = anyGnt & ~winInWindow;
    respIsRead_d = anyGnt & ~winWe;
  end

  // State registers; an asynchronous reset drops any response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt_q    <= 4'd0;
      respValid_q  <= 1'b0;
      respOwner_q  <= OwnerP;
      respErr_q    <= 1'b0;
      respIsRead_q <= 1'b0;
    end else begin
      waitCnt_q    <= waitCnt_d;
      respValid_q  <= respValid_d;
      respOwner_q  <= respOwner_d;
      respErr_q    <= respErr_d;
      respIsRead_q <= respIsRead_d;
    end
  end

  // Route the response to its owner. Writes and errors return zero data.
  always_comb begin
    p_rvalid_o = respValid_q & (respOwner_q == OwnerP);
    d_rvalid_o = respValid_q & (respOwner_q == OwnerD);
    p_err_o    = p_rvalid_o & respErr_q;
    d_err_o    = d_rvalid_o & respErr_q;
    p_rdata_o  = (p_rvalid_o && respIsRead_q && !respErr_q) ? mem_rdata_i : 32'd0;
    d_rdata_o  = (d_rvalid_o && respIsRead_q && !respErr_q) ? mem_rdata_i : 32'd0;
  end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench for riscv_dmem_arbiter with a read-first synchronous RAM model.
module tb_riscv_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req, p_we, d_req, d_we;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
  logic        p_gnt, p_rvalid, p_err, d_gnt, d_rvalid, d_err;
  logic [31:0] p_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] memArray [0:2047];

  int total = 0;
  int bad   = 0;

  riscv_dmem_arbiter #(
    .DATA_START_ADDRESS(32'h00800000),
    .DATA_BRAMS(2),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_gnt_o(p_gnt), .p_rvalid_o(p_rvalid), .p_rdata_o(p_rdata), .p_err_o(p_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // 10-unit clock; posedges at 5, 15, ...
  always #5 clk = ~clk;

  // Read-first synchronous RAM, one cycle of read latency.
  always @(posedge clk) begin
    mem_rdata <= memArray[mem_addr[12:2]];
    if (mem_we) memArray[mem_addr[12:2]] <= mem_wdata;
  end

  task automatic applyStimulus(input logic pr, input logic pw, input logic [31:0] pa,
                               input logic [31:0] pd, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd);
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  logic [5:0] pGntExp;
  logic [5:0] dGntExp;

  initial begin
    for (int i = 0; i < 2048; i++) memArray[i] = 32'd0;
    memArray[0] = 32'hA0A0A0A0;
    memArray[1] = 32'hDEADBEEF;
    memArray[2] = 32'hC2C2C2C2;
    pGntExp = 6'b101111;
    dGntExp = 6'b010000;

    // Reset with a pending P request: no grant may leak out.
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h00800004, 32'd0, 1'b1, 1'b0, 32'h00800000, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_p_gnt", 32'(p_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_p_rvalid", 32'(p_rvalid), 32'd0);
    checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("rst_wait_cnt", 32'(dut.waitCnt_q), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // P read of word 1.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h00800004, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("rd_p_gnt", 32'(p_gnt), 32'd1);
    checkOutput("rd_d_gnt", 32'(d_gnt), 32'd0);
    @(negedge clk);
    idle();
    #1;
    checkOutput("rd_p_rvalid", 32'(p_rvalid), 32'd1);
    checkOutput("rd_p_rdata", p_rdata, 32'hDEADBEEF);
    checkOutput("rd_p_err", 32'(p_err), 32'd0);
    checkOutput("rd_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("rd_d_rdata", d_rdata, 32'd0);

    // P write to word 4, then read it back two cycles later.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h00800010, 32'h12345678, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
    checkOutput("wr_mem_addr", mem_addr, 32'h00800010);
    checkOutput("wr_mem_wdata", mem_wdata, 32'h12345678);
    @(negedge clk);
    idle();
    #1;
    checkOutput("wr_mem_we_once", 32'(mem_we), 32'd0);
    checkOutput("wr_ack_rvalid", 32'(p_rvalid), 32'd1);
    checkOutput("wr_ack_rdata", p_rdata, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h00800010, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("rb_p_gnt", 32'(p_gnt), 32'd1);
    @(negedge clk);
    idle();
    #1;
    checkOutput("rb_p_rdata", p_rdata, 32'h12345678);

    // Contention: both request reads for six cycles, D forced in cycle 4.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 32'h00800000, 32'd0, 1'b1, 1'b0, 32'h00800004, 32'd0);
      #1;
      checkOutput($sformatf("ct_p_gnt_c%0d", c), 32'(p_gnt), 32'(pGntExp[c]));
      checkOutput($sformatf("ct_d_gnt_c%0d", c), 32'(d_gnt), 32'(dGntExp[c]));
      if (c == 4) checkOutput("ct_wait_c4", 32'(dut.waitCnt_q), 32'd4);
      if (c == 5) begin
        checkOutput("ct_wait_c5", 32'(dut.waitCnt_q), 32'd0);
        checkOutput("ct_d_rvalid_c5", 32'(d_rvalid), 32'd1);
        checkOutput("ct_d_rdata_c5", d_rdata, 32'hDEADBEEF);
        checkOutput("ct_p_rvalid_c5", 32'(p_rvalid), 32'd0);
      end
    end
    @(negedge clk);
    idle();
    #1;
    checkOutput("ct_p_rvalid_c6", 32'(p_rvalid), 32'd1);
    checkOutput("ct_p_rdata_c6", p_rdata, 32'hA0A0A0A0);

    // Out-of-window D write.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h00400000, 32'hFFFFFFFF);
    #1;
    checkOutput("oow_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("oow_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    idle();
    #1;
    checkOutput("oow_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("oow_d_err", 32'(d_err), 32'd1);
    checkOutput("oow_d_rdata", d_rdata, 32'd0);
    checkOutput("oow_p_rvalid", 32'(p_rvalid), 32'd0);

    // Out-of-window P read.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h10000000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("oor_p_gnt", 32'(p_gnt), 32'd1);
    @(negedge clk);
    idle();
    #1;
    checkOutput("oor_p_rvalid", 32'(p_rvalid), 32'd1);
    checkOutput("oor_p_rdata", p_rdata, 32'd0);
    checkOutput("oor_p_err", 32'(p_err), 32'd1);

    // Back-to-back alternation: P w0, D w1, P w2.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h00800000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("bb_c0_p_gnt", 32'(p_gnt), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h00800004, 32'd0);
    #1;
    checkOutput("bb_c1_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("bb_c1_p_rvalid", 32'(p_rvalid), 32'd1);
    checkOutput("bb_c1_p_rdata", p_rdata, 32'hA0A0A0A0);
    checkOutput("bb_c1_d_rvalid", 32'(d_rvalid), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h00800008, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput("bb_c2_p_gnt", 32'(p_gnt), 32'd1);
    checkOutput("bb_c2_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("bb_c2_d_rdata", d_rdata, 32'hDEADBEEF);
    checkOutput("bb_c2_p_rvalid", 32'(p_rvalid), 32'd0);
    checkOutput("bb_c2_p_rdata", p_rdata, 32'd0);
    @(negedge clk);
    idle();
    #1;
    checkOutput("bb_c3_p_rvalid", 32'(p_rvalid), 32'd1);
    checkOutput("bb_c3_p_rdata", p_rdata, 32'hC2C2C2C2);
    checkOutput("bb_c3_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("bb_c3_d_rdata", d_rdata, 32'd0);

    // Reset mid-operation: P read granted while D waits, then reset while the response is out.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h00800000, 32'd0, 1'b1, 1'b0, 32'h00800004, 32'd0);
    #1;
    checkOutput("mr_p_gnt", 32'(p_gnt), 32'd1);
    @(negedge clk);
    idle();
    #1;
    checkOutput("mr_p_rvalid_pre", 32'(p_rvalid), 32'd1);
    checkOutput("mr_wait_pre", 32'(dut.waitCnt_q), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_p_rvalid_rst", 32'(p_rvalid), 32'd0);
    checkOutput("mr_wait_rst", 32'(dut.waitCnt_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mr_p_rvalid_post", 32'(p_rvalid), 32'd0);
    checkOutput("mr_d_rvalid_post", 32'(d_rvalid), 32'd0);
    checkOutput("mr_wait_post", 32'(dut.waitCnt_q), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
